// File: rtl/nn_pkg.sv
// Shared CNN-pipeline types: FSM state encoding and the pixel-counter width.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int pix_cnt_w(input int size);
    int n;
    n = size * size;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/concat_ctrl_if.sv
// Trunk/branch input strobes and the concatenated output stream.
interface concat_ctrl_if #(
  parameter int N             = 8,
  parameter int INPUT_CHANNEL = 1
);
  import nn_pkg::*;

  localparam int W = INPUT_CHANNEL * N;

  logic           layer_vld;
  logic [W-1:0]   layer_din;
  logic           branch_vld;
  logic [W-1:0]   branch_din;
  logic           concat_dout_vld;
  logic [2*W-1:0] concat_dout;

  modport master (
    output layer_vld, layer_din,
    output branch_vld, branch_din,
    input  concat_dout_vld, concat_dout
  );

  modport slave (
    input  layer_vld, layer_din,
    input  branch_vld, branch_din,
    output concat_dout_vld, concat_dout
  );

endinterface

// File: rtl/concat_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
module concat_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Head is read combinationally, so a same-cycle write to a
  // full FIFO cannot disturb the entry being popped.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/concat_ctrl.sv
// Trunk/branch pairing buffer with frame sequencing.
// Build with CONCAT_CTRL_ERR_EN to get sticky err_ovf/err_udf flags.
module concat_ctrl
  import nn_pkg::*;
#(
  parameter int N             = 8,
  parameter int INPUT_CHANNEL = 1,
  parameter int INPUT_SIZE    = 28,
  parameter int DEPTH         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  concat_ctrl_if.slave           bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_ovf,
  output logic                   err_udf
);

  localparam int W    = INPUT_CHANNEL * N;
  localparam int CW   = pix_cnt_w(INPUT_SIZE);
  localparam int LAST = INPUT_SIZE * INPUT_SIZE - 1;

  logic           fifo_full;
  logic           fifo_empty;
  logic [W-1:0]   head;
  logic           pop;
  logic           push;
  logic           bypass;
  logic           emit;
  logic           vld_q;
  logic [2*W-1:0] dout_q;
  logic [CW-1:0]  pix_cnt;
  state_t         state_q;
  state_t         state_d;

  assign pop    = bus.branch_vld && !fifo_empty;
  assign bypass = bus.branch_vld && bus.layer_vld && fifo_empty;
  assign emit   = pop || bypass;
  assign push   = bus.layer_vld && !bypass &&
                  (!fifo_full || pop);

  concat_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.layer_din),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q <= emit;
      if (emit)
        dout_q <= {bus.branch_din,
                   pop ? head : bus.layer_din};
    end
  end

  assign bus.concat_dout_vld = vld_q;
  assign bus.concat_dout     = dout_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.layer_vld || bus.branch_vld)
          state_d = ST_ACTIVE;
      ST_ACTIVE:
        if (vld_q && pix_cnt == CW'(LAST))
          state_d = ST_DONE;
      ST_DONE:
        if (!fifo_empty || bus.layer_vld ||
            bus.branch_vld)
          state_d = ST_ACTIVE;
        else
          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // An output landing during DONE is the first pixel of the next frame.
  always_ff @(posedge clk) begin
    if (rst)
      pix_cnt <= '0;
    else if (state_q == ST_DONE)
      pix_cnt <= vld_q ? CW'(1) : '0;
    else if (vld_q)
      pix_cnt <= pix_cnt + CW'(1);
  end

  assign busy       = (state_q == ST_ACTIVE);
  assign frame_done = (state_q == ST_DONE);

`ifdef CONCAT_CTRL_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.layer_vld && fifo_full && !pop)
        ovf_q <= 1'b1;
      if (bus.branch_vld && fifo_empty &&
          !bus.layer_vld)
        udf_q <= 1'b1;
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: doc/concat_ctrl.md
Name: concat_ctrl

Overview:
Sequencer and pairing buffer for channel concatenation in the CNN pipeline. Sits at the merge point after a trunk layer and its skip branch. It buffers trunk (layer) pixels in a small FIFO until the matching branch pixel arrives, emits the concatenated word, counts pixels per frame and flags ordering faults. This removes the fixed-latency assumption between trunk and branch.

Parameters:
N, 8, bit width of one channel element
INPUT_CHANNEL, 1, channels per input stream
INPUT_SIZE, 28, feature-map side length; a frame is INPUT_SIZE*INPUT_SIZE pixels
DEPTH, 4, FIFO entries for outstanding layer pixels; must be a power of 2 and at least 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
layer_vld  in  1  trunk pixel valid, single-cycle strobe
layer_din  in  INPUT_CHANNEL*N  trunk pixel
branch_vld  in  1  branch pixel valid, single-cycle strobe
branch_din  in  INPUT_CHANNEL*N  branch pixel
concat_dout_vld  out  1  output valid, one-cycle pulse
concat_dout  out  2*INPUT_CHANNEL*N  concatenated word {branch, layer}
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  high while state is ACTIVE
frame_done  out  1  one-cycle pulse after the last pixel of a frame is emitted
err_ovf  out  1  sticky flag: layer push dropped because the FIFO was full
err_udf  out  1  sticky flag: branch arrived with no layer data available

Behaviour:
- Reset values: all outputs 0; FIFO pointers 0; pixel counter 0; state IDLE. Reset overrides all other inputs in the same cycle, including mid-frame. Any in-flight FIFO contents are discarded.
- FIFO: write pointer and read pointer are each $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty.
  - full is true when the pointer MSBs differ and the lower bits are equal.
  - fifo_level = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
- Pairing, evaluated each cycle:
  - branch_vld with FIFO non-empty: pop the head. Next cycle concat_dout = {branch_din, head} and concat_dout_vld = 1. Latency is one cycle.
  - branch_vld and layer_vld together with FIFO empty: bypass. Next cycle concat_dout = {branch_din, layer_din} and concat_dout_vld = 1. No FIFO write; level stays 0.
  - branch_vld with FIFO empty and no layer_vld: no output. Set err_udf; the branch pixel is dropped.
  - layer_vld with FIFO full and no pop in the same cycle: drop the push and set err_ovf.
  - layer_vld with FIFO full and a pop in the same cycle: accept both; level is unchanged.
  - Simultaneous push and pop with FIFO non-empty: both proceed; the popped entry is the old head.
- concat_dout holds its last value when concat_dout_vld = 0.
- State machine:
  - IDLE -> ACTIVE on the first layer_vld or branch_vld.
  - ACTIVE: the pixel counter increments on each emitted output. When the counter reaches INPUT_SIZE*INPUT_SIZE-1 and an output is emitted, go to DONE.
  - DONE, one cycle: frame_done = 1, counter cleared, then go to IDLE. If the FIFO is non-empty (next frame already arriving), go directly to ACTIVE instead.
  - Inputs arriving during DONE are processed normally and counted toward the next frame.
- Error flags clear only on rst.

Optional Feature:
CONCAT_CTRL_ERR_EN
- Defined: err_ovf and err_udf are implemented as described above.
- Not defined: both flags are tied to 0 and the error registers are not built. Drop behaviour (ignored push, ignored branch) is unchanged.

Decomposition:
- Shared package nn_pkg holds:
  - state enum constants: ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DONE = 2'd2
  - helper function for the pixel-count width: $clog2(INPUT_SIZE*INPUT_SIZE)
- One natural sub-module: concat_fifo, a synchronous FIFO parameterized by width and depth. It exposes push, pop, dout, full, empty and level. Pairing logic, counter and FSM stay in concat_ctrl.

Test Plan:
- Setup for all scenarios: N=8, INPUT_CHANNEL=1, INPUT_SIZE=2, DEPTH=4.
- layer 0x11, then 3 cycles later branch 0xA1 -> next cycle concat_dout = 0xA111, vld = 1; fifo_level goes 1 -> 0.
- layer and branch strobed in the same cycle with FIFO empty (0x22, 0xB2) -> bypass, next cycle 0xB222; fifo_level stays 0.
- 4 layers 0x01..0x04 then a 5th 0x05 with no branch -> fifo_level = 4, err_ovf = 1. The next 4 branches 0xC0..0xC3 yield 0xC001..0xC304; 0x05 is never emitted.
- FIFO full and layer + branch in the same cycle -> pop emits the old head, push accepted, level stays 4, err_ovf stays 0.
- 4 paired pixels -> frame_done pulses once, in the cycle after the 4th concat_dout_vld; busy drops unless the FIFO is non-empty.
- branch with FIFO empty -> err_udf = 1, no concat_dout_vld. Assert rst mid-frame with level = 2 -> next cycle all outputs 0, state IDLE, level 0.
